// File: rtl/fetch_queue.sv
// Instruction fetch unit: drives a synchronous instruction memory and buffers the
// returned words in a small FIFO, with single-cycle branch redirect and flush.
module fetch_queue #(
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 4,
   parameter int INST_W   = 32,
   parameter int RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_rd,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INST_W-1:0]          imem_data,
   output logic                       inst_valid,
   output logic [INST_W-1:0]          inst,
   output logic [31:0]                inst_pc,
   input  logic                       inst_ready,
   input  logic                       br_valid,
   input  logic [31:0]                br_target,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [31:0]                fetch_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] fpc_q;
   logic [ADDR_W-1:0] infl_addr_q;
   logic              inflight_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;

   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];

   logic [CNT_W:0]    pending;
   logic              issue;
   logic              push;
   logic              pop;
   logic [ADDR_W+1:0] head_byte;
   logic [ADDR_W+1:0] fetch_byte;
   logic              unused_ok;

   // Reserve a slot for the read already in flight so a push can never overflow.
   assign pending = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign issue   = !br_valid && (pending < DEPTH_C);
   assign push    = inflight_q && !br_valid;
   assign pop     = (count_q != '0) && inst_ready;

   assign imem_rd    = issue && !reset;
   assign imem_addr  = fpc_q;
   assign inst_valid = (count_q != '0) && !reset;
   assign occupancy  = reset ? '0 : count_q;
   assign inst       = inst_mem[head_q];
   assign head_byte  = {addr_mem[head_q], 2'b00};
   assign fetch_byte = {fpc_q, 2'b00};
   assign inst_pc    = 32'(head_byte);
   assign fetch_pc   = 32'(fetch_byte);

   assign unused_ok = ^{br_target[1:0], br_target[31:ADDR_W+2]};

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fpc_q       <= ADDR_W'(RESET_PC);
         infl_addr_q <= '0;
         inflight_q  <= 1'b0;
         count_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
      end else if (br_valid) begin
         // Flush wins over push and pop; the returning read is simply dropped.
         fpc_q      <= br_target[ADDR_W+1:2];
         inflight_q <= 1'b0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         inflight_q <= issue;
         count_q    <= count_d;
         if (issue) begin
            fpc_q       <= fpc_q + 1'b1;
            infl_addr_q <= fpc_q;
         end
         if (push) begin
            tail_q <= tail_q + 1'b1;
         end
         if (pop) begin
            head_q <= head_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         inst_mem[tail_q] <= imem_data;
         addr_mem[tail_q] <= infl_addr_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/stall, hand sequences
// for redirect, mid-stream reset and address wrap (second instance, ADDR_W = 4).
module tb_fetch_queue;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, default parameters
   logic        reset, imem_rd, inst_valid, inst_ready, br_valid;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data, inst, inst_pc, br_target, fetch_pc;
   logic [2:0]  occupancy;

   fetch_queue dut (
      .clk(clk), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr),
      .imem_data(imem_data), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .br_valid(br_valid), .br_target(br_target),
      .occupancy(occupancy), .fetch_pc(fetch_pc)
   );

   // Narrow-address instance for wrap-around
   logic        w_reset, w_imem_rd, w_inst_valid;
   logic [3:0]  w_imem_addr;
   logic [31:0] w_imem_data, w_inst, w_inst_pc, w_fetch_pc;
   logic [2:0]  w_occupancy;

   fetch_queue #(.ADDR_W(4)) dut_w (
      .clk(clk), .reset(w_reset), .imem_rd(w_imem_rd), .imem_addr(w_imem_addr),
      .imem_data(w_imem_data), .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
      .inst_ready(1'b1), .br_valid(1'b0), .br_target(32'h0),
      .occupancy(w_occupancy), .fetch_pc(w_fetch_pc)
   );

   // Memory model: word n holds 0xA0000000 | n, returned one cycle after the strobe
   always @(posedge clk) begin
      if (imem_rd) imem_data <= 32'hA000_0000 | {24'h0, imem_addr};
      if (w_imem_rd) w_imem_data <= 32'hA000_0000 | {28'h0, w_imem_addr};
   end

   int total = 0;
   int bad = 0;
   int ncyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        br;
      logic [31:0] tgt;
      logic        ev;
      logic [31:0] epc;
      int          eocc;
      logic        erd;
      logic [7:0]  eaddr;
   } vec_t;

   function automatic vec_t v(input logic rst, rdy, br, input logic [31:0] tgt,
                              input logic ev, input logic [31:0] epc, input int eocc,
                              input logic erd, input logic [7:0] eaddr);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.br = br; r.tgt = tgt;
      r.ev = ev; r.epc = epc; r.eocc = eocc; r.erd = erd; r.eaddr = eaddr;
      return r;
   endfunction

   // Drive one cycle's inputs at the falling edge, then check outputs before the rising edge
   task automatic cyc(input vec_t x);
      @(negedge clk);
      reset = x.rst; inst_ready = x.rdy; br_valid = x.br; br_target = x.tgt;
      #1;
      $display("cyc %0d: rst=%b rdy=%b br=%b valid=%b pc=%h occ=%0d rd=%b addr=%h",
               ncyc, x.rst, x.rdy, x.br, inst_valid, inst_pc, occupancy, imem_rd, imem_addr);
      check($sformatf("c%0d inst_valid", ncyc), {31'h0, inst_valid}, {31'h0, x.ev});
      check($sformatf("c%0d occupancy", ncyc), {29'h0, occupancy}, x.eocc);
      check($sformatf("c%0d imem_rd", ncyc), {31'h0, imem_rd}, {31'h0, x.erd});
      check($sformatf("c%0d imem_addr", ncyc), {24'h0, imem_addr}, {24'h0, x.eaddr});
      check($sformatf("c%0d fetch_pc", ncyc), fetch_pc, {22'h0, x.eaddr, 2'b00});
      if (x.ev) begin
         check($sformatf("c%0d inst_pc", ncyc), inst_pc, x.epc);
         check($sformatf("c%0d inst", ncyc), inst, 32'hA000_0000 | (x.epc >> 2));
      end
      ncyc++;
   endtask

   vec_t vecs[$];

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; inst_ready = 1'b1; br_valid = 1'b0; br_target = 32'h0;
      w_reset = 1'b1;
      repeat (2) @(posedge clk);

      // Streaming from reset with ready held high
      vecs.push_back(v(1, 1, 0, 0, 0, 0,     0, 0, 8'h00));
      vecs.push_back(v(0, 1, 0, 0, 0, 0,     0, 1, 8'h00));
      vecs.push_back(v(0, 1, 0, 0, 0, 0,     0, 1, 8'h01));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h0, 1, 1, 8'h02));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h4, 1, 1, 8'h03));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h8, 1, 1, 8'h04));
      vecs.push_back(v(1, 0, 0, 0, 0, 0,     0, 0, 8'h05));
      // Ten cycles of back-pressure from reset release: fill to DEPTH, fetch stops
      vecs.push_back(v(0, 0, 0, 0, 0, 0,     0, 1, 8'h00));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,     0, 1, 8'h01));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 1, 1, 8'h02));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 2, 1, 8'h03));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 3, 0, 8'h04));
      for (int i = 0; i < 5; i++) vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 4, 0, 8'h04));
      // Release: pop at full does not issue, then four pops and streaming resumes
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h0,  4, 0, 8'h04));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h4,  3, 1, 8'h04));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h8,  2, 1, 8'h05));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'hC,  2, 1, 8'h06));
      vecs.push_back(v(0, 1, 0, 0, 1, 32'h10, 2, 1, 8'h07));

      foreach (vecs[i]) cyc(vecs[i]);

      // One-cycle reset mid-stream at occupancy 2, restart with ready low
      cyc(v(1, 0, 0, 0, 0, 0,     0, 0, 8'h08));
      cyc(v(0, 0, 0, 0, 0, 0,     0, 1, 8'h00));
      cyc(v(0, 0, 0, 0, 0, 0,     0, 1, 8'h01));
      cyc(v(0, 0, 0, 0, 1, 32'h0, 1, 1, 8'h02));
      cyc(v(0, 0, 0, 0, 1, 32'h0, 2, 1, 8'h03));
      // Redirect to 0x40 at occupancy 3; stale word 3 must not appear
      cyc(v(0, 0, 1, 32'h40, 1, 32'h0,  3, 0, 8'h04));
      cyc(v(0, 0, 0, 0,      0, 0,      0, 1, 8'h10));
      cyc(v(0, 0, 0, 0,      0, 0,      0, 1, 8'h11));
      cyc(v(0, 1, 0, 0,      1, 32'h40, 1, 1, 8'h12));
      cyc(v(0, 1, 0, 0,      1, 32'h44, 1, 1, 8'h13));
      // Redirect coinciding with a handshake, target low bits ignored
      cyc(v(0, 1, 1, 32'h7,  1, 32'h48, 1, 0, 8'h14));
      cyc(v(0, 1, 0, 0,      0, 0,      0, 1, 8'h01));
      cyc(v(0, 1, 0, 0,      0, 0,      0, 1, 8'h02));
      cyc(v(0, 1, 0, 0,      1, 32'h4,  1, 1, 8'h03));
      // Back-to-back redirects: the second target wins
      cyc(v(0, 1, 1, 32'h100, 1, 32'h8,  1, 0, 8'h04));
      cyc(v(0, 1, 1, 32'h20,  0, 0,      0, 0, 8'h40));
      cyc(v(0, 1, 0, 0,       0, 0,      0, 1, 8'h08));
      cyc(v(0, 1, 0, 0,       0, 0,      0, 1, 8'h09));
      cyc(v(0, 1, 0, 0,       1, 32'h20, 1, 1, 8'h0A));

      // Wrap-around with a 4-bit word address: 0x3C is followed by 0x00
      @(negedge clk);
      w_reset = 1'b0;
      for (int k = 0; k < 22; k++) begin
         #1;
         if (k < 2) begin
            check($sformatf("wrap k%0d inst_valid", k), {31'h0, w_inst_valid}, 32'h0);
         end else begin
            $display("wrap k=%0d: valid=%b pc=%h inst=%h", k, w_inst_valid, w_inst_pc, w_inst);
            check($sformatf("wrap k%0d inst_valid", k), {31'h0, w_inst_valid}, 32'h1);
            check($sformatf("wrap k%0d inst_pc", k), w_inst_pc, ((k - 2) * 4) & 32'h3F);
            check($sformatf("wrap k%0d inst", k), w_inst, 32'hA000_0000 | ((k - 2) & 32'hF));
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
